// File: rtl/nfifo_param.sv
// -----------------------------------------------------------------------------
// nfifo_param: parametrised synchronous FIFO with first-word-fall-through
// read data, occupancy count and threshold status flags.
//
// Compile-time option:
//   NFIFO_ERR_FLAGS_EN : when defined, builds sticky overflow/underflow flags
//                        (ovf_o / udf_o). When undefined, both are tied to 0.
//
// data_o always shows the head entry. A push into an empty FIFO becomes
// visible one cycle later, because there is no same-cycle bypass. Status flags
// are decoded from the registered count, so they change in the same cycle as
// count_o.
// -----------------------------------------------------------------------------
module nfifo_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int AFULL_TH  = 6,
  parameter int AEMPTY_TH = 2
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       write_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       read_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic                       afull_o,
  output logic                       aempty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       ovf_o,
  output logic                       udf_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Thresholds are cast to the count width so that every comparison is between
  // operands of equal width.
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  logic wr;
  logic rd;

  // Status flags are decoded from the registered count.
  always_comb begin
    empty_o  = (count_q == '0);
    full_o   = (count_q == DEPTH_C);
    afull_o  = (count_q >= AFULL_C);
    aempty_o = (count_q <= AEMPTY_C);
    count_o  = count_q;
    data_o   = mem_q[rptr_q];
  end

  // Qualify the requests. A push is accepted while full only when a pop in
  // the same cycle frees the slot it fills. A pop is never accepted when the
  // FIFO is empty.
  always_comb begin
    wr = write_i & (~full_o | read_i);
    rd = read_i & ~empty_o;
  end

  // Compute the next pointer and count values.
  // DEPTH is a power of two, so the pointers wrap naturally modulo DEPTH.
  always_comb begin
    // NOTE: every combinational output gets a default value first, so no
    //       path through the block can leave a value held and infer a latch.
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr) wptr_d = wptr_q + AW'(1);
    if (rd) rptr_d = rptr_q + AW'(1);
    unique case ({wr, rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers. An asynchronous reset empties the FIFO
  // immediately.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    //       flop samples values from before the clock edge.
    if (!rstn_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array, written on an accepted push.
  always_ff @(posedge clk_i) begin
    // NOTE: the array has no reset. Resetting the pointers and the count is
    //       enough to discard its contents, and leaving the reset off keeps
    //       the array a plain register file or RAM.
    if (wr) mem_q[wptr_q] <= data_i;
  end

`ifdef NFIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // Sticky error flags. They only observe the interface and never affect the
  // data path.
  always_comb begin
    ovf_d = ovf_q | (write_i & full_o & ~read_i);
    udf_d = udf_q | (read_i & empty_o);
  end

  // Error flag registers. They clear only on reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf_o = ovf_q;
  assign udf_o = udf_q;
`else
  assign ovf_o = 1'b0;
  assign udf_o = 1'b0;
`endif

endmodule

// File: tb/tb_nfifo_param.sv
// -----------------------------------------------------------------------------
// tb_nfifo_param: self-checking bench for nfifo_param (WIDTH=8, DEPTH=8,
// AFULL_TH=6, AEMPTY_TH=2). A queue-based reference model predicts all
// outputs. Directed scenarios are followed by a randomized run.
// Follows NFIFO_ERR_FLAGS_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_nfifo_param;

  localparam int WIDTH     = 8;
  localparam int DEPTH     = 8;
  localparam int AFULL_TH  = 6;
  localparam int AEMPTY_TH = 2;

`ifdef NFIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             clk_i = 1'b0;
  logic             rstn_i;
  logic             write_i;
  logic [WIDTH-1:0] data_i;
  logic             read_i;
  logic [WIDTH-1:0] data_o;
  logic             empty_o;
  logic             full_o;
  logic             afull_o;
  logic             aempty_o;
  logic [3:0]       count_o;
  logic             ovf_o;
  logic             udf_o;

  nfifo_param #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .AFULL_TH (AFULL_TH),
    .AEMPTY_TH(AEMPTY_TH)
  ) dut (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .write_i (write_i),
    .data_i  (data_i),
    .read_i  (read_i),
    .data_o  (data_o),
    .empty_o (empty_o),
    .full_o  (full_o),
    .afull_o (afull_o),
    .aempty_o(aempty_o),
    .count_o (count_o),
    .ovf_o   (ovf_o),
    .udf_o   (udf_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: the FIFO contents as a queue, plus the sticky flags.
  logic [WIDTH-1:0] model_q[$];
  bit               m_ovf;
  bit               m_udf;
  int               max_count;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every DUT output with the value the model predicts.
  task automatic check_all(input string tag);
    int n;
    n = model_q.size();
    check({tag, ":count"},  count_o, n);
    check({tag, ":empty"},  empty_o, (n == 0));
    check({tag, ":full"},   full_o,  (n == DEPTH));
    check({tag, ":afull"},  afull_o, (n >= AFULL_TH));
    check({tag, ":aempty"}, aempty_o, (n <= AEMPTY_TH));
    check({tag, ":ovf"},    ovf_o,   ERR_EN & m_ovf);
    check({tag, ":udf"},    udf_o,   ERR_EN & m_udf);
    if (n != 0) check({tag, ":data"}, data_o, model_q[0]);
  endtask

  // Run one clock cycle. Inputs are driven and outputs checked at the
  // negedge, and the model advances at the posedge.
  task automatic cycle(input string tag, input logic w, input logic [WIDTH-1:0] d, input logic r);
    bit full_m, empty_m;
    write_i = w;
    data_i  = d;
    read_i  = r;
    check_all(tag);
    @(posedge clk_i);
    full_m  = (model_q.size() == DEPTH);
    empty_m = (model_q.size() == 0);
    if (w && full_m && !r) m_ovf = 1'b1;
    if (r && empty_m)      m_udf = 1'b1;
    if (r && !empty_m)     void'(model_q.pop_front());
    if (w && (!full_m || r)) model_q.push_back(d);
    if (model_q.size() > max_count) max_count = model_q.size();
    @(negedge clk_i);
  endtask

  // Pulse the reset between clock edges and check that the FIFO clears
  // without a clock edge.
  task automatic pulse_reset(input string tag);
    write_i = 1'b0;
    read_i  = 1'b0;
    #1 rstn_i = 1'b0;
    model_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    #1 check_all(tag);
    #1 rstn_i = 1'b1;
    @(negedge clk_i);
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    bit w, r;
    rstn_i  = 1'b0;
    write_i = 1'b0;
    read_i  = 1'b0;
    data_i  = '0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    repeat (2) @(negedge clk_i);
    check_all("reset");
    rstn_i = 1'b1;
    @(negedge clk_i);

    // 1: fill with 1..8, then drain in order.
    for (int i = 1; i <= 8; i++) cycle("fill", 1'b1, 8'(i), 1'b0);
    check("fill_full", full_o, 1'b1);
    for (int i = 0; i < 8; i++) cycle("drain", 1'b0, 8'h00, (model_q.size() != 0));
    check("drain_empty", empty_o, 1'b1);

    // 2: a write while full is dropped.
    for (int i = 1; i <= 8; i++) cycle("refill", 1'b1, 8'(i), 1'b0);
    cycle("ovf", 1'b1, 8'hAA, 1'b0);
    cycle("ovf", 1'b1, 8'hAA, 1'b0);
    check("ovf_count", count_o, 4'd8);
    check("ovf_flag", ovf_o, ERR_EN);

    // 3: a simultaneous push and pop while full.
    cycle("fullrw", 1'b1, 8'h55, 1'b1);
    check("fullrw_head", data_o, 8'h02);
    for (int i = 0; i < 8; i++) cycle("fullrw_drain", 1'b0, 8'h00, (model_q.size() != 0));
    check("fullrw_empty", empty_o, 1'b1);

    // 4: stream 1..20 with read_i following the model's empty state.
    pulse_reset("rst4");
    max_count = 0;
    for (int i = 1; i <= 20; i++) cycle("stream", 1'b1, 8'(i), (model_q.size() != 0));
    while (model_q.size() != 0) cycle("stream_tail", 1'b0, 8'h00, 1'b1);
    check("stream_maxcount", max_count, 1);
    check("stream_ovf", ovf_o, 1'b0);
    check("stream_udf", udf_o, 1'b0);

    // 5: a read while empty is ignored.
    cycle("udf", 1'b0, 8'h00, 1'b1);
    check("udf_count", count_o, 4'd0);
    check("udf_flag", udf_o, ERR_EN);
    cycle("udf_after", 1'b1, 8'h3C, 1'b0);
    check("udf_head", data_o, 8'h3C);
    cycle("udf_pop", 1'b0, 8'h00, 1'b1);

    // 6: reset mid-operation discards stale data.
    for (int i = 0; i < 5; i++) cycle("pre_rst", 1'b1, 8'(8'hC0 + i), 1'b0);
    pulse_reset("midrst");
    check("midrst_empty", empty_o, 1'b1);
    check("midrst_count", count_o, 4'd0);
    cycle("post_rst", 1'b1, 8'h99, 1'b0);
    check("post_rst_head", data_o, 8'h99);
    cycle("post_rst_pop", 1'b0, 8'h00, 1'b1);

    // Randomized traffic with alternating write-heavy and read-heavy phases.
    for (int i = 0; i < 600; i++) begin
      bit heavy_wr;
      heavy_wr = ((i / 40) % 2) == 0;
      w = heavy_wr ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
      r = heavy_wr ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
      d = 8'($urandom);
      cycle("rand", w, d, r);
      if (i == 300) pulse_reset("rand_rst");
    end
    check_all("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
